// File: rtl/seg7_scan_reader.sv
// ---------------------------------------------------------------------------
// seg7_scan_reader
//
// Snoops a multiplexed 4-digit seven-segment display bus (active-low segments
// and active-low digit enables) and recovers the hex nibble shown on each
// digit. A digit is accepted once its pattern has been stable for
// STABLE_CYCLES consecutive samples. A frame completes when all four digits
// have been accepted.
//
// Parameters:
//   STABLE_CYCLES - consecutive identical samples needed to accept (2..15)
//   ERR_W         - width of the saturating invalid-pattern counter
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   seg[6:0]   - segment bus {g,f,e,d,c,b,a}, active-low
//   an[3:0]    - digit enables, active-low, an[i]=0 selects digit i
//   digits     - accepted nibbles, digit i at [4i+3:4i]
//   blank      - digit i last accepted as all-off
//   seen       - digit i accepted at least once in the current frame
//   frame_done - one-cycle pulse when a frame completes
//   err        - one-cycle pulse on acceptance of an unrecognised pattern
//   err_count  - saturating count of err pulses
// ---------------------------------------------------------------------------
module seg7_scan_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       seg,
    input  logic [3:0]       an,
    output logic [15:0]      digits,
    output logic [3:0]       blank,
    output logic [3:0]       seen,
    output logic             frame_done,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0] STABLE     = 4'(STABLE_CYCLES);
    localparam logic [3:0] STABLE_M1  = 4'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_COLLECT,
        ST_DONE
    } state_t;

    // Input stage plus the previous sample used for the stability compare
    logic [6:0]       r_seg;
    logic [3:0]       r_an;
    logic [6:0]       r_segPrev;
    logic [3:0]       r_anPrev;
    logic [3:0]       r_cnt;

    logic [15:0]      r_digits;
    logic [3:0]       r_blank;
    logic [3:0]       r_seen;
    logic             r_frameDone;
    logic             r_err;
    logic [ERR_W-1:0] r_errCount;
    state_t           r_state;

    logic             w_selValid;
    logic [1:0]       w_selIdx;
    logic             w_same;
    logic [3:0]       w_cntNext;
    logic             w_accept;
    logic             w_codeValid;
    logic             w_codeBlank;
    logic [3:0]       w_nibble;
    logic             w_hit;
    logic [15:0]      w_digitsNext;
    logic [3:0]       w_blankNext;
    logic             w_errNext;
    logic [ERR_W-1:0] w_errCountNext;
    logic [3:0]       w_seenNext;
    state_t           w_stateNext;
    logic             w_frameDoneNext;

    // Exactly one enable low is a valid select; anything else is ignored
    always_comb begin
        w_selValid = 1'b1;
        w_selIdx   = 2'd0;
        case (r_an)
            4'b1110: w_selIdx = 2'd0;
            4'b1101: w_selIdx = 2'd1;
            4'b1011: w_selIdx = 2'd2;
            4'b0111: w_selIdx = 2'd3;
            default: w_selValid = 1'b0;
        endcase
    end

    // Stability counter: acceptance happens only on the step into STABLE,
    // so a held pattern is accepted exactly once
    always_comb begin
        w_same = (r_seg == r_segPrev) && (r_an == r_anPrev);
        if (!w_selValid) begin
            w_cntNext = 4'd0;
        end else if (w_same) begin
            w_cntNext = (r_cnt == STABLE) ? r_cnt : r_cnt + 4'd1;
        end else begin
            w_cntNext = 4'd1;
        end
        w_accept = w_selValid && w_same && (r_cnt == STABLE_M1);
    end

    // Segment decode (active-low, {g,f,e,d,c,b,a})
    always_comb begin
        w_codeValid = 1'b1;
        w_codeBlank = 1'b0;
        w_nibble    = 4'h0;
        case (r_seg)
            7'h40: w_nibble = 4'h0;
            7'h79: w_nibble = 4'h1;
            7'h24: w_nibble = 4'h2;
            7'h30: w_nibble = 4'h3;
            7'h19: w_nibble = 4'h4;
            7'h12: w_nibble = 4'h5;
            7'h02: w_nibble = 4'h6;
            7'h78: w_nibble = 4'h7;
            7'h00: w_nibble = 4'h8;
            7'h10: w_nibble = 4'h9;
            7'h08: w_nibble = 4'hA;
            7'h03: w_nibble = 4'hB;
            7'h46: w_nibble = 4'hC;
            7'h21: w_nibble = 4'hD;
            7'h06: w_nibble = 4'hE;
            7'h0E: w_nibble = 4'hF;
            7'h7F: begin
                w_codeValid = 1'b0;
                w_codeBlank = 1'b1;
            end
            default: w_codeValid = 1'b0;
        endcase
    end

    // Per-digit update on acceptance; invalid codes only raise err
    always_comb begin
        w_digitsNext   = r_digits;
        w_blankNext    = r_blank;
        w_errNext      = 1'b0;
        w_errCountNext = r_errCount;
        w_hit          = w_accept && (w_codeValid || w_codeBlank);
        if (w_accept) begin
            if (w_codeValid) begin
                w_digitsNext[w_selIdx*4 +: 4] = w_nibble;
                w_blankNext[w_selIdx]         = 1'b0;
            end else if (w_codeBlank) begin
                w_blankNext[w_selIdx] = 1'b1;
            end else begin
                w_errNext = 1'b1;
                if (r_errCount != {ERR_W{1'b1}}) begin
                    w_errCountNext = r_errCount + 1'b1;
                end
            end
        end
    end

    // Frame FSM: in DONE the seen clear applies before any same-cycle set
    always_comb begin
        w_seenNext      = (r_state == ST_DONE) ? 4'h0 : r_seen;
        w_stateNext     = ST_COLLECT;
        w_frameDoneNext = 1'b0;
        if (w_hit) begin
            w_seenNext[w_selIdx] = 1'b1;
        end
        if ((r_state == ST_COLLECT) && w_hit && (w_seenNext == 4'hF)) begin
            w_stateNext     = ST_DONE;
            w_frameDoneNext = 1'b1;
        end
    end

    // All state registers; the input stage resets to an invalid select so
    // the first post-reset acceptance needs a full run of fresh samples
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg       <= 7'h7F;
            r_an        <= 4'hF;
            r_segPrev   <= 7'h7F;
            r_anPrev    <= 4'hF;
            r_cnt       <= 4'd0;
            r_digits    <= 16'h0000;
            r_blank     <= 4'hF;
            r_seen      <= 4'h0;
            r_frameDone <= 1'b0;
            r_err       <= 1'b0;
            r_errCount  <= '0;
            r_state     <= ST_COLLECT;
        end else begin
            r_seg       <= seg;
            r_an        <= an;
            r_segPrev   <= r_seg;
            r_anPrev    <= r_an;
            r_cnt       <= w_cntNext;
            r_digits    <= w_digitsNext;
            r_blank     <= w_blankNext;
            r_seen      <= w_seenNext;
            r_frameDone <= w_frameDoneNext;
            r_err       <= w_errNext;
            r_errCount  <= w_errCountNext;
            r_state     <= w_stateNext;
        end
    end

    assign digits     = r_digits;
    assign blank      = r_blank;
    assign seen       = r_seen;
    assign frame_done = r_frameDone;
    assign err        = r_err;
    assign err_count  = r_errCount;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_reader
//
// Directed testbench for seg7_scan_reader. Inputs change just after the
// falling edge; outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_seg7_scan_reader;

    logic        clk;
    logic        reset;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  seen;
    logic        frame_done;
    logic        err;
    logic [7:0]  err_count;

    int checks;
    int errors;
    int fdCount;
    int errPulses;

    seg7_scan_reader #(
        .STABLE_CYCLES(4),
        .ERR_W        (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .seg       (seg),
        .an        (an),
        .digits    (digits),
        .blank     (blank),
        .seen      (seen),
        .frame_done(frame_done),
        .err       (err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle at a time, tallying output pulses seen at each negedge
    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (frame_done) fdCount++;
            if (err) errPulses++;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] anVal, input logic [6:0] segVal,
                                 input int n);
        an  = anVal;
        seg = segVal;
        waitCycles(n);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        fdCount   = 0;
        errPulses = 0;
        reset     = 1'b1;
        seg       = 7'h7F;
        an        = 4'hF;

        // Reset values
        waitCycles(2);
        reset = 1'b0;
        checkOutput("rst_digits", 32'(digits), 32'h0000);
        checkOutput("rst_blank", 32'(blank), 32'hF);
        checkOutput("rst_seen", 32'(seen), 32'h0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_err_count", 32'(err_count), 32'h0);

        // Single digit: not yet accepted after 4 edges, accepted on the 5th
        applyStimulus(4'b1110, 7'h24, 4);
        checkOutput("d0_early_digits", 32'(digits), 32'h0000);
        checkOutput("d0_early_seen", 32'(seen), 32'h0);
        waitCycles(2);
        checkOutput("d0_digits", 32'(digits), 32'h0002);
        checkOutput("d0_blank", 32'(blank), 32'hE);
        checkOutput("d0_seen", 32'(seen), 32'h1);
        checkOutput("d0_err", 32'(errPulses), 32'd0);

        // Full scan of four digits
        fdCount = 0;
        applyStimulus(4'b1110, 7'h30, 8);
        applyStimulus(4'b1101, 7'h19, 8);
        checkOutput("scan_seen_mid", 32'(seen), 32'h3);
        applyStimulus(4'b1011, 7'h12, 8);
        applyStimulus(4'b0111, 7'h02, 8);
        checkOutput("scan_digits", 32'(digits), 32'h6543);
        checkOutput("scan_blank", 32'(blank), 32'h0);
        checkOutput("scan_frame_done", 32'(fdCount), 32'd1);
        checkOutput("scan_seen_clr", 32'(seen), 32'h0);

        // Stable invalid pattern
        errPulses = 0;
        applyStimulus(4'b1101, 7'h55, 10);
        checkOutput("inv_err_pulses", 32'(errPulses), 32'd1);
        checkOutput("inv_err_count", 32'(err_count), 32'd1);
        checkOutput("inv_digits", 32'(digits), 32'h6543);
        checkOutput("inv_seen", 32'(seen), 32'h0);

        // Toggling pattern never settles, then a held pattern is accepted
        applyStimulus(4'b1110, 7'h40, 2);
        applyStimulus(4'b1110, 7'h79, 2);
        applyStimulus(4'b1110, 7'h40, 2);
        applyStimulus(4'b1110, 7'h79, 2);
        applyStimulus(4'b1110, 7'h40, 2);
        checkOutput("tog_digits", 32'(digits), 32'h6543);
        checkOutput("tog_seen", 32'(seen), 32'h0);
        applyStimulus(4'b1110, 7'h79, 6);
        checkOutput("hold_digits", 32'(digits), 32'h6541);
        checkOutput("hold_seen", 32'(seen), 32'h1);

        // Two enables low is ignored; blank code keeps the nibble
        applyStimulus(4'b1100, 7'h00, 10);
        checkOutput("multi_digits", 32'(digits), 32'h6541);
        checkOutput("multi_seen", 32'(seen), 32'h1);
        applyStimulus(4'b0111, 7'h7F, 6);
        checkOutput("blank_blank", 32'(blank), 32'h8);
        checkOutput("blank_digits", 32'(digits), 32'h6541);
        checkOutput("blank_seen", 32'(seen), 32'h9);
        checkOutput("blank_err_count", 32'(err_count), 32'd1);

        // Reset during the third cycle of a hold
        applyStimulus(4'b1011, 7'h0E, 2);
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        checkOutput("mid_rst_digits", 32'(digits), 32'h0000);
        checkOutput("mid_rst_blank", 32'(blank), 32'hF);
        checkOutput("mid_rst_seen", 32'(seen), 32'h0);
        checkOutput("mid_rst_err_count", 32'(err_count), 32'd0);
        waitCycles(4);
        checkOutput("post_rst_early", 32'(digits), 32'h0000);
        waitCycles(1);
        checkOutput("post_rst_digits", 32'(digits), 32'h0F00);
        checkOutput("post_rst_blank", 32'(blank), 32'hB);
        checkOutput("post_rst_seen", 32'(seen), 32'h4);

        // 300 invalid acceptances: count tracks, then saturates at 255
        for (int i = 0; i < 100; i++) begin
            applyStimulus(4'b1110, (i % 2 == 0) ? 7'h55 : 7'h2A, 4);
        end
        waitCycles(1);
        checkOutput("sat_count_100", 32'(err_count), 32'd100);
        for (int i = 0; i < 200; i++) begin
            applyStimulus(4'b1110, (i % 2 == 0) ? 7'h55 : 7'h2A, 4);
        end
        waitCycles(2);
        checkOutput("sat_count_255", 32'(err_count), 32'd255);
        checkOutput("sat_digits", 32'(digits), 32'h0F00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
